// File: rtl/pc_sequencer.sv
// Next-PC selection for the fetch stage: boot hold, sequential fetch, branch,
// exception/eret redirect, and a one-entry buffer for redirects seen under stall.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC     = 32'h0000_4180,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        flush,
  output logic        pend_valid,
  output logic        misalign
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pend_q, pend_d;
  logic               pv_q, pv_d;

  logic [31:0]        seq_pc;
  logic [31:0]        tgt;
  logic               tgt_chk;

  assign seq_pc     = pc_cur + 32'd4;
  assign pend_valid = pv_q;

  // State, boot counter and pending-redirect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      pend_q  <= 32'h0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
    end
  end

  // Next-state and source selection; priority exc > eret > pending > branch > pc+4
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    pc_en    = 1'b0;
    flush    = 1'b0;
    tgt      = RESET_PC;
    tgt_chk  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (cnt_q >= BOOT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (exc_req) begin
          pc_en   = 1'b1;
          flush   = 1'b1;
          tgt     = EXC_VEC;
          pend_d  = 32'h0;
          pv_d    = 1'b0;
          state_d = ST_RUN;
        end else if (eret_req) begin
          pc_en   = 1'b1;
          flush   = 1'b1;
          tgt     = epc;
          tgt_chk = 1'b1;
          pend_d  = 32'h0;
          pv_d    = 1'b0;
          state_d = ST_RUN;
        end else if (stall) begin
          // First redirect seen under stall wins; later ones are dropped
          tgt     = seq_pc;
          state_d = ST_HOLD;
          if (br_taken && !pv_q) begin
            pend_d = br_target;
            pv_d   = 1'b1;
          end
        end else begin
          pc_en   = 1'b1;
          pend_d  = 32'h0;
          pv_d    = 1'b0;
          state_d = ST_RUN;
          if (pv_q) begin
            tgt     = pend_q;
            tgt_chk = 1'b1;
          end else if (br_taken) begin
            tgt     = br_target;
            tgt_chk = 1'b1;
          end else begin
            tgt     = seq_pc;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = '0;
        pend_d  = 32'h0;
        pv_d    = 1'b0;
      end
    endcase
  end

  // Force word alignment on redirect targets and flag the correction
  always_comb begin
    pc_next  = tgt;
    misalign = 1'b0;
    if (tgt_chk) begin
      pc_next  = {tgt[31:2], 2'b00};
      misalign = pc_en && (tgt[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot hold, sequential fetch, stalled branch,
// exception/eret priority, wraparound, misalignment and reset during HOLD.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        flush;
  logic        pend_valid;
  logic        misalign;

  int checks;
  int failures;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pc_cur     (pc_cur),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc_next    (pc_next),
    .pc_en      (pc_en),
    .flush      (flush),
    .pend_valid (pend_valid),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; br_taken = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    pc_cur = 32'h0000_3000;
    br_target = 32'h0;
    epc = 32'h0;
    idle();

    // Reset state
    #3;
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_pc_next", pc_next, 32'h0000_3000);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_pend_valid", 32'(pend_valid), 32'd0);

    #4 reset = 1'b1;
    #1;
    chk("boot0_pc_en", 32'(pc_en), 32'd0);

    // First boot edge: requests must be ignored
    tick();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3100; exc_req = 1'b1;
    #2;
    chk("boot1_pc_en", 32'(pc_en), 32'd0);
    chk("boot1_flush", 32'(flush), 32'd0);
    chk("boot1_pc_next", pc_next, 32'h0000_3000);
    idle();

    // Second edge: RUN
    tick();
    #2;
    chk("run_pc_en", 32'(pc_en), 32'd1);
    chk("run_pc_next", pc_next, 32'h0000_3004);
    chk("boot_no_capture", 32'(pend_valid), 32'd0);

    // Stalled branch buffered; later branches under stall ignored
    pc_cur = 32'h0000_3010;
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3100;
    #1;
    chk("stall_pc_en", 32'(pc_en), 32'd0);
    chk("stall_pv_pre", 32'(pend_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      br_target = 32'h0000_3200;
      #2;
      chk("hold_pc_en", 32'(pc_en), 32'd0);
      chk("hold_pend_valid", 32'(pend_valid), 32'd1);
    end
    tick();
    stall = 1'b0; br_taken = 1'b0;
    #2;
    chk("release_pc_en", 32'(pc_en), 32'd1);
    chk("release_pc_next", pc_next, 32'h0000_3100);
    chk("release_flush", 32'(flush), 32'd0);
    tick();
    #2;
    chk("post_release_pv", 32'(pend_valid), 32'd0);
    chk("post_release_next", pc_next, 32'h0000_3014);

    // Exception beats eret and stall, clears pending
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3300;
    tick();
    br_taken = 1'b0;
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_5000;
    #2;
    chk("exc_pv_before", 32'(pend_valid), 32'd1);
    chk("exc_pc_en", 32'(pc_en), 32'd1);
    chk("exc_pc_next", pc_next, 32'h0000_4180);
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_misalign", 32'(misalign), 32'd0);
    tick();
    idle();
    #2;
    chk("exc_pv_after", 32'(pend_valid), 32'd0);
    chk("idle_flush", 32'(flush), 32'd0);

    // Eret alone with misaligned epc
    eret_req = 1'b1; epc = 32'h0000_3009;
    #1;
    chk("eret_pc_next", pc_next, 32'h0000_3008);
    chk("eret_misalign", 32'(misalign), 32'd1);
    chk("eret_flush", 32'(flush), 32'd1);
    tick();
    idle();

    // Wraparound and misaligned branch
    pc_cur = 32'hFFFF_FFFC;
    #1;
    chk("wrap_pc_next", pc_next, 32'h0000_0000);
    chk("wrap_misalign", 32'(misalign), 32'd0);
    br_taken = 1'b1; br_target = 32'h0000_3006;
    #1;
    chk("mis_pc_next", pc_next, 32'h0000_3004);
    chk("mis_misalign", 32'(misalign), 32'd1);
    chk("mis_flush", 32'(flush), 32'd0);
    tick();
    idle();

    // Reset pulsed during HOLD discards the pending target
    pc_cur = 32'h0000_3020;
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_7000;
    tick();
    br_taken = 1'b0;
    #2;
    chk("hold2_pv", 32'(pend_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_pv", 32'(pend_valid), 32'd0);
    chk("midrst_pc_en", 32'(pc_en), 32'd0);
    chk("midrst_pc_next", pc_next, 32'h0000_3000);
    idle();
    #2 reset = 1'b1;
    tick();
    #2;
    chk("reboot1_pc_en", 32'(pc_en), 32'd0);
    tick();
    #2;
    chk("reboot_pc_en", 32'(pc_en), 32'd1);
    chk("reboot_pc_next", pc_next, 32'h0000_3024);
    chk("reboot_misalign", 32'(misalign), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
